// File: rtl/ej32_pkg.sv
// Shared eJ32 core types: stack operation encoding and default data-stack depth.
package ej32_pkg;

  typedef enum logic [1:0] {
    sNOP  = 2'd0,
    sPUSH = 2'd1,
    sPOP  = 2'd2,
    sREPL = 2'd3
  } stack_op;

  localparam int SS_DEPTH = 64;
  localparam int SS_DSZ   = 32;

endpackage

// File: rtl/ej32_ram_1r1w.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read of the address being written in the same cycle returns the new data.
module ej32_ram_1r1w #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= (we && waddr == raddr) ? wdata : mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ej32_sstack.sv
// eJ32 data stack responder: TOS/NOS in registers, deeper entries in RAM with a
// prefetched read of the top RAM word so pops sustain one per clock.
module ej32_sstack
  import ej32_pkg::*;
#(
  parameter int DEPTH = SS_DEPTH,
  parameter int DSZ   = SS_DSZ
) (
  input  logic                       clk,
  input  logic                       rst,
  input  stack_op                    op,
  input  logic [DSZ-1:0]             vi,
  output logic [DSZ-1:0]             s,
  output logic [DSZ-1:0]             n,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic                       ovf,
  output logic                       unf,
  input  logic                       err_clr
);

  localparam int CW  = $clog2(DEPTH+1);
  localparam int SPW = $clog2(DEPTH-1);   // sp spans 0..DEPTH-2

  logic [DSZ-1:0] s_q, s_d, n_q, n_d, ram_q;
  logic [SPW-1:0] sp_q, sp_d, rd_addr;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic           we, empty, full, do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_push = (op == sPUSH) || (op == sREPL && empty);
  assign do_pop  = (op == sPOP);

  always_comb begin
    s_d   = s_q;
    n_d   = n_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    we    = 1'b0;
    ovf_d = ovf_q & ~err_clr;
    unf_d = unf_q & ~err_clr;
    if (do_push) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        s_d   = vi;
        n_d   = s_q;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q >= CW'(2)) begin
          we   = 1'b1;
          sp_d = sp_q + SPW'(1);
        end
      end
    end else if (do_pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        s_d   = n_q;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q >= CW'(3)) begin
          n_d  = ram_q;
          sp_d = sp_q - SPW'(1);
        end else begin
          n_d  = '0;
        end
      end
    end else if (op == sREPL) begin
      s_d = vi;
    end
  end

  // Prefetch the word that will sit just below NOS after this cycle's update;
  // when sp_d is 0 the read is unused and its wrapped address is harmless.
  assign rd_addr = sp_d - SPW'(1);

  ej32_ram_1r1w #(.DW(DSZ), .AW(SPW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (sp_q),
    .wdata (n_q),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= '0;
      n_q   <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      n_q   <= n_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign s   = s_q;
  assign n   = n_q;
  assign cnt = cnt_q;
  assign ovf = ovf_q;
  assign unf = unf_q;

endmodule
